mst_fifo_slv_model: RTL
=======================

Name: mst_fifo_slv_model

Overview:
- Synthesizable model of the FT600 slave end of the 245-style synchronous Master FIFO bus: the chip-side responder to the FPGA master FSM.
- Serves bursts of incrementing 16-bit words on the read path.
- Accepts, buffers and sequence-checks words on the write path, draining at a programmable rate to exercise TXE_N back-pressure.
- Used in FPGA loopback builds and as the bus partner in master-side benches.

Parameters:
- AW, 4, write buffer address width; depth DEPTH = 2^AW words.
- RD_BURST, 64, words offered per read burst before RXF_N deasserts (1..65535).
- RD_GAP, 8, cycles RXF_N stays high between bursts (1..255).
- DRAIN_DIV, 2, write buffer pops one word every DRAIN_DIV cycles while non-empty (1..255).

Ports:
- clk  in  1  bus clock, the same CLK seen by the master.
- rst_n  in  1  asynchronous active-low reset.
- wr_n  in  1  master write strobe, active low.
- rd_n  in  1  master read strobe, active low.
- oe_n  in  1  master output-enable request, active low.
- idata  in  16  bus data from master.
- ibe  in  2  byte enables from master.
- txe_n  out  1  registered; low = slave can accept writes.
- rxf_n  out  1  registered; low = slave has read data.
- odata  out  16  read data toward master.
- obe  out  2  read byte enables, constant 2'b11.
- dt_oe_n  out  1  low = slave drives DATA/BE (equals oe_n).
- seq_err  out  1  sticky; write data sequence mismatch.
- proto_err  out  1  sticky; bus protocol violation.
- wr_cnt  out  16  words accepted, wraps.
- rd_cnt  out  16  words delivered, wraps.

Behaviour:
- Reset values:
  - txe_n=0, rxf_n=1 (gap state, gap counter=RD_GAP), odata=0, dt_oe_n=1.
  - seq_err=0, proto_err=0, wr_cnt=0, rd_cnt=0.
  - Buffer empty, expected word=0, drain divider=0.
- Reset is asynchronous; assertion mid-burst abandons all state immediately.
- Read path FSM, states GAP and SERVE:
  - GAP: counter decrements each cycle. At 1, the next edge sets rxf_n=0, loads the burst counter with RD_BURST and enters SERVE.
  - SERVE: odata holds the current generator word, presented combinationally from a register, so it is valid whenever oe_n=0.
  - A word is consumed on an edge with oe_n=0, rd_n=0 and rxf_n=0. On consumption: generator +1 (mod 2^16), rd_cnt +1, burst counter -1.
  - Consuming the last word (burst counter=1) sets rxf_n=1 at that same edge and returns to GAP with counter=RD_GAP.
  - Generator value persists across bursts; a master sequence checker sees 0,1,2,... continuously.
  - rd_n=0 while oe_n=1, or while rxf_n=1: no consumption, no error.
- Write path:
  - A word is accepted on an edge with wr_n=0, txe_n=0 and oe_n=1. On acceptance, {ibe,idata} is pushed and wr_cnt +1.
  - txe_n <= (next_count == DEPTH), using the post-push/pop occupancy, so no overflow is possible. txe_n returns low the edge after occupancy drops below DEPTH.
  - Drain: a divider counts 0..DRAIN_DIV-1. A pop occurs when the divider wraps and the buffer is non-empty. Simultaneous push and pop keeps the count unchanged.
  - Checker on pop: if ibe==2'b11, compare data to the expected value. On mismatch set seq_err and resync expected to data+1; otherwise expected+1.
  - Words with ibe!=2'b11 (partial tail) are not compared and do not advance expected.
- Protocol errors: proto_err is set on any edge with wr_n=0 and oe_n=0. That write is rejected; read consumption proceeds per the read rules.
- Counters wrap 0xFFFF->0.

Test Plan:
- Reset release, RD_BURST=4, RD_GAP=3: rxf_n falls 3 cycles after reset. Master OE then RD for 4 cycles -> odata 0,1,2,3. rxf_n high on the 4th consume edge, low again 3 cycles later; next odata=4, rd_cnt=4.
- AW=2, DRAIN_DIV=4: master writes 0..9 back-to-back honouring txe_n -> txe_n rises when occupancy reaches 4, no word lost, wr_cnt=10, seq_err=0 after drain.
- Write sequence 0,1,2,7,8 -> seq_err rises on the pop of 7 and stays 1; checker resyncs and 8 raises no new mismatch.
- Write ending with ibe=2'b01 word 0x00AA after 0..2 -> no seq_err; next full word 3 is accepted as in-sequence.
- wr_n=0 with oe_n=0 for one edge -> proto_err=1, wr_cnt unchanged, and a concurrent read consumption still increments rd_cnt.
- Assert rst_n mid-burst with buffer holding 3 words -> all outputs return to reset values asynchronously; after release the read sequence restarts at 0.

Source files
------------

// File: rtl/mst_fifo_slv_model.sv
// mst_fifo_slv_model: FT600 245-style sync master-FIFO slave model; in clk rst_n wr_n rd_n oe_n idata ibe; out txe_n rxf_n odata obe dt_oe_n seq_err proto_err wr_cnt rd_cnt
module mst_fifo_slv_model #(
  parameter int AW        = 4,
  parameter int RD_BURST  = 64,
  parameter int RD_GAP    = 8,
  parameter int DRAIN_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_n,
  input  logic        rd_n,
  input  logic        oe_n,
  input  logic [15:0] idata,
  input  logic [1:0]  ibe,
  output logic        txe_n,
  output logic        rxf_n,
  output logic [15:0] odata,
  output logic [1:0]  obe,
  output logic        dt_oe_n,
  output logic        seq_err,
  output logic        proto_err,
  output logic [15:0] wr_cnt,
  output logic [15:0] rd_cnt
);
  localparam int DEPTH = 1 << AW;
  typedef enum logic {GAP, SERVE} state_t;
  state_t state;
  logic [7:0] gap_cnt, div;
  logic [15:0] burst_cnt, gen, exp_word;
  logic [17:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count, next_count;
  logic consume, push, pop;
  logic [17:0] head;
  assign consume = !oe_n && !rd_n && !rxf_n;
  assign push = !wr_n && !txe_n && oe_n;
  assign pop = div == 8'(DRAIN_DIV - 1) && count != '0;
  assign next_count = count + (AW+1)'(push) - (AW+1)'(pop);
  assign head = mem[rptr];
  assign odata = gen;
  assign obe = 2'b11;
  assign dt_oe_n = oe_n | ~rst_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= GAP;
      gap_cnt <= 8'(RD_GAP);
      burst_cnt <= '0;
      rxf_n <= 1'b1;
      gen <= '0;
      rd_cnt <= '0;
    end else if (state == GAP) begin
      gap_cnt <= gap_cnt - 8'd1;
      if (gap_cnt == 8'd1) begin
        state <= SERVE;
        rxf_n <= 1'b0;
        burst_cnt <= 16'(RD_BURST);
      end
    end else if (consume) begin
      gen <= gen + 16'd1;
      rd_cnt <= rd_cnt + 16'd1;
      burst_cnt <= burst_cnt - 16'd1;
      if (burst_cnt == 16'd1) begin
        state <= GAP;
        rxf_n <= 1'b1;
        gap_cnt <= 8'(RD_GAP);
      end
    end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= {ibe, idata};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div <= '0;
      count <= '0;
      txe_n <= 1'b0;
      wptr <= '0;
      rptr <= '0;
      wr_cnt <= '0;
      exp_word <= '0;
      seq_err <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      div <= div == 8'(DRAIN_DIV - 1) ? '0 : div + 8'd1;
      count <= next_count;
      txe_n <= next_count == (AW+1)'(DEPTH);
      if (push) begin
        wptr <= wptr + 1'b1;
        wr_cnt <= wr_cnt + 16'd1;
      end
      if (pop) rptr <= rptr + 1'b1;
      if (pop && head[17:16] == 2'b11) begin
        exp_word <= head[15:0] + 16'd1;
        seq_err <= seq_err | (head[15:0] != exp_word);
      end
      if (!wr_n && !oe_n) proto_err <= 1'b1;
    end
endmodule
